wb_sub_arbiter: RTL and testbench
=================================

# wb_sub_arbiter

Routes Caravel Wishbone transactions from the user-project slave port to one of two subordinate Wishbone engines: subordinate 0 is the Fibonacci control logic and subordinate 1 is the SHA-1 engine. Routing is by address decode, replacing static `active`/`la_data_in` muxing of `wbs_ack_o`/`wbs_dat_o`. The block registers the subordinate-side strobes and guards each transaction with a timeout that returns an error word and raises a sticky interrupt. An optional local statistics register counts routed transactions and timeouts.

## Interface
- `BASE`, 4'h3: required value of `wbs_adr_i[31:28]`. Other addresses are ignored: no ack, no subordinate activity.
- `SEL_BIT`, 8: address bit choosing the subordinate (0 → s0, 1 → s1).
- `TIMEOUT`, 16: cycles in BUSY before forced error completion. Range 2..255.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_ni`  in  1  reset, asynchronous, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  master control.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  master address/write data.
- `wbs_ack_o`  out  1  one-cycle completion pulse.
- `wbs_dat_o`  out  32  read data, valid with `wbs_ack_o`.
- `s0_cyc_o`, `s0_stb_o`, `s0_we_o`  out  1 each; `s0_sel_o`  out  4; `s0_adr_o`, `s0_dat_o`  out  32: subordinate 0 request (registered).
- `s0_ack_i`  in  1; `s0_dat_i`  in  32: subordinate 0 response.
- `s1_*`: identical set for subordinate 1.
- `irq_o`  out  1  level; high while sticky timeout flag set.

## Operation
- FSM states: IDLE, BUSY, DONE, plus LOCAL when stats are compiled in.
- IDLE → BUSY: when `wbs_cyc_i & wbs_stb_i` and `wbs_adr_i[31:28]==BASE`.
  - Latch adr/dat/we/sel and target = `wbs_adr_i[SEL_BIT]`.
  - Assert target's `cyc`/`stb` from the next cycle. The other subordinate stays idle (all outputs 0).
  - Clear timeout counter.
- BUSY, target ack: capture `sN_dat_i` into `wbs_dat_o`. Drop `sN_cyc`/`sN_stb` at the same edge. Go to DONE.
- BUSY, no ack while counter == TIMEOUT-1: drop strobes, set `wbs_dat_o` = 32'hDEADBEEF, set sticky timeout flag, go to DONE.
  - A late subordinate ack (strobe already low) is ignored.
- BUSY, `wbs_cyc_i` low (master abort): drop strobes, return to IDLE, no ack, no counter update.
- Ack from the non-target subordinate is ignored in every state.
- DONE: `wbs_ack_o`=1 for exactly this cycle, then IDLE.
- Write transactions: `wbs_dat_o` = captured subordinate data, or 32'hDEADBEEF on timeout.
- Counters saturate; they never wrap.
- Reset (any state, mid-transaction included): all outputs 0 asynchronously, state IDLE, flag and counters cleared.

## Timing
- Request accepted on edge N. Subordinate strobes are high from N+1.
- Subordinate ack sampled on edge M. `wbs_ack_o` is high during cycle M+1.
- Minimum latency, request to ack: 3 cycles.
- Timeout: `wbs_ack_o` asserts TIMEOUT+1 cycles after acceptance. `irq_o` rises in the same cycle as that ack.
- A new request may be accepted in the cycle after DONE. Strobe still high during DONE is not a new request.

## Configuration
- `WB_ARB_STATS_EN` defined: address `{BASE, …, adr[7:0]==8'hFC}` is a local register, bypassing both subordinates. Match on `adr[31:28]` and `adr[7:0]` only.
  - Read returns {tmo_cnt[7:0], s1_cnt[11:0], s0_cnt[11:0]}.
  - Any write clears all three counters and the sticky flag.
  - Path is IDLE → LOCAL → DONE, so ack arrives 2 cycles after acceptance.
  - s0_cnt/s1_cnt increment on each subordinate-acked transaction. tmo_cnt increments on each timeout.
- Not defined: no counters. Address 0xFC routes to a subordinate like any other. Sticky flag is cleared only by reset.

## Test plan
- Read 0x3000_0004, s0 acks 1 cycle after strobe with 0x0000_0055 → `s1_*` all 0; `wbs_dat_o`=0x55, ack 3 cycles after acceptance.
- Write 0x3000_0100 data 0xA5A5_A5A5, s1 acks → `s1_dat_o`=0xA5A5A5A5, `s1_we_o`=1, single ack pulse.
- Read 0x3000_0000, s0 never acks, TIMEOUT=16 → ack at cycle 17 with 0xDEADBEEF, `irq_o`=1. s0 ack at cycle 20 → no second ack.
- Read 0x2000_0000 → no ack and no subordinate strobe for 50 cycles.
- Drop `wbs_cyc_i` in BUSY, then assert `wb_rst_ni`=0 mid-transaction in a second run → no ack; all outputs 0 immediately on reset.
- With `WB_ARB_STATS_EN`: two s0 reads, one s1 write, one timeout, then read 0x3000_00FC → 0x01001002. Write 0x3000_00FC → next read 0, `irq_o`=0.

Source files
------------

// File: rtl/wb_sub_arbiter.sv
// ---------------------------------------------------------------------------
// wb_sub_arbiter
//
// Routes Caravel Wishbone slave-port transactions to one of two subordinate
// Wishbone engines by address decode. Subordinate 0 is the Fibonacci control
// logic. Subordinate 1 is the SHA-1 engine.
//
// Decode rules:
//   - wbs_adr_i[31:28] must equal BASE, otherwise the request is ignored.
//   - wbs_adr_i[SEL_BIT] selects the subordinate.
//
// Every routed transaction is guarded by a TIMEOUT-cycle watchdog. On expiry
// the arbiter returns 32'hDEADBEEF and sets a sticky interrupt flag.
//
// Optional feature (macro WB_ARB_STATS_EN):
//   A local register at {BASE, ..., adr[7:0]==8'hFC} bypasses both
//   subordinates.
//   - Read returns {tmo_cnt[7:0], s1_cnt[11:0], s0_cnt[11:0]}.
//   - Any write clears the counters and the sticky flag.
//   - Without the macro, 0xFC routes like any other address, and the flag is
//     cleared only by reset.
//
// Ports:
//   wb_clk_i, wb_rst_ni           clock, async active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i    master control
//   wbs_adr_i, wbs_dat_i          master address / write data
//   wbs_ack_o, wbs_dat_o          completion pulse / read data
//   s0_*_o, s1_*_o                subordinate requests (idle side all zero)
//   s0_ack_i/dat_i, s1_ack_i/dat_i  subordinate responses
//   irq_o                         high while the sticky timeout flag is set
// ---------------------------------------------------------------------------
module wb_sub_arbiter #(
    parameter logic [3:0] BASE    = 4'h3,
    parameter int         SEL_BIT = 8,
    parameter int         TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        s0_cyc_o,
    output logic        s0_stb_o,
    output logic        s0_we_o,
    output logic [3:0]  s0_sel_o,
    output logic [31:0] s0_adr_o,
    output logic [31:0] s0_dat_o,
    input  logic        s0_ack_i,
    input  logic [31:0] s0_dat_i,
    output logic        s1_cyc_o,
    output logic        s1_stb_o,
    output logic        s1_we_o,
    output logic [3:0]  s1_sel_o,
    output logic [31:0] s1_adr_o,
    output logic [31:0] s1_dat_o,
    input  logic        s1_ack_i,
    input  logic [31:0] s1_dat_i,
    output logic        irq_o
);

    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
`ifdef WB_ARB_STATS_EN
        DONE  = 2'd2,
        LOCAL = 2'd3
`else
        DONE  = 2'd2
`endif
    } state_t;

    state_t      state, state_nxt;

    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        req_we;
    logic        tgt;        // latched subordinate select
    logic        stb_q;      // subordinate strobe, high only while BUSY
    logic [7:0]  tcnt;       // watchdog counter
    logic [31:0] dat_q;
    logic        ack_q;
    logic        flag_q;

`ifdef WB_ARB_STATS_EN
    logic [11:0] s0_cnt;
    logic [11:0] s1_cnt;
    logic [7:0]  tmo_cnt;
`endif

    logic hit;
    logic tgt_ack;
    logic sub_ack;
    logic tmo;

    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE);
    // Only the latched target's ack counts; the other subordinate is ignored.
    assign tgt_ack = tgt ? s1_ack_i : s0_ack_i;

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        sub_ack   = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
`ifdef WB_ARB_STATS_EN
                    if (wbs_adr_i[7:0] == 8'hFC) begin
                        state_nxt = LOCAL;
                    end else begin
                        state_nxt = BUSY;
                    end
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                // Master abort wins over a simultaneous ack: no completion.
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (tgt_ack) begin
                    state_nxt = DONE;
                    sub_ack   = 1'b1;
                end else if (tcnt == TMO_LAST) begin
                    state_nxt = DONE;
                    tmo       = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
`ifdef WB_ARB_STATS_EN
            LOCAL: begin
                state_nxt = DONE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, watchdog, response capture, sticky flag and statistics
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            req_adr <= '0;
            req_dat <= '0;
            req_sel <= '0;
            req_we  <= 1'b0;
            tgt     <= 1'b0;
            stb_q   <= 1'b0;
            tcnt    <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            flag_q  <= 1'b0;
`ifdef WB_ARB_STATS_EN
            s0_cnt  <= '0;
            s1_cnt  <= '0;
            tmo_cnt <= '0;
`endif
        end else begin
            ack_q <= (state_nxt == DONE);

            if (state == IDLE && state_nxt != IDLE) begin
                req_adr <= wbs_adr_i;
                req_dat <= wbs_dat_i;
                req_sel <= wbs_sel_i;
                req_we  <= wbs_we_i;
                tgt     <= wbs_adr_i[SEL_BIT];
                stb_q   <= (state_nxt == BUSY);
                tcnt    <= '0;
            end else if (state == BUSY) begin
                // Strobes drop on ack, timeout or abort; a later ack is
                // therefore never seen because BUSY has been left.
                if (state_nxt != BUSY) begin
                    stb_q <= 1'b0;
                end else begin
                    tcnt <= tcnt + 8'd1;
                end
            end

            if (sub_ack) begin
                dat_q <= tgt ? s1_dat_i : s0_dat_i;
            end
            if (tmo) begin
                dat_q  <= ERR_WORD;
                flag_q <= 1'b1;
            end

`ifdef WB_ARB_STATS_EN
            if (state == LOCAL) begin
                if (req_we) begin
                    s0_cnt  <= '0;
                    s1_cnt  <= '0;
                    tmo_cnt <= '0;
                    flag_q  <= 1'b0;
                    dat_q   <= '0;
                end else begin
                    dat_q <= {tmo_cnt, s1_cnt, s0_cnt};
                end
            end
            // Counters saturate rather than wrap.
            if (sub_ack && !tgt && s0_cnt != 12'hFFF) begin
                s0_cnt <= s0_cnt + 12'd1;
            end
            if (sub_ack && tgt && s1_cnt != 12'hFFF) begin
                s1_cnt <= s1_cnt + 12'd1;
            end
            if (tmo && tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
`endif
        end
    end

    // Subordinate request buses: registered values gated so that the
    // non-target side and every side outside BUSY present all zeros.
    logic act0, act1;
    assign act0 = stb_q & ~tgt;
    assign act1 = stb_q &  tgt;

    assign s0_cyc_o  = act0;
    assign s0_stb_o  = act0;
    assign s0_we_o   = act0 & req_we;
    assign s0_sel_o  = act0 ? req_sel : 4'h0;
    assign s0_adr_o  = act0 ? req_adr : 32'h0;
    assign s0_dat_o  = act0 ? req_dat : 32'h0;

    assign s1_cyc_o  = act1;
    assign s1_stb_o  = act1;
    assign s1_we_o   = act1 & req_we;
    assign s1_sel_o  = act1 ? req_sel : 4'h0;
    assign s1_adr_o  = act1 ? req_adr : 32'h0;
    assign s1_dat_o  = act1 ? req_dat : 32'h0;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = flag_q;

endmodule

// File: tb/tb_wb_sub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_sub_arbiter
//
// Directed bench for wb_sub_arbiter (default parameters, TIMEOUT = 16).
// Two simple subordinate responders ack one cycle after seeing a strobe when
// enabled. A kick input per subordinate injects stray acks. Cycle numbers
// count from the cycle in which the arbiter accepts the request (cycle 0).
// ---------------------------------------------------------------------------
module tb_wb_sub_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;

    wire         wbs_ack_o;
    wire  [31:0] wbs_dat_o;
    wire         s0_cyc_o, s0_stb_o, s0_we_o, s1_cyc_o, s1_stb_o, s1_we_o;
    wire  [3:0]  s0_sel_o, s1_sel_o;
    wire  [31:0] s0_adr_o, s0_dat_o, s1_adr_o, s1_dat_o;
    wire         s0_ack_i, s1_ack_i;
    wire         irq_o;

    logic        en0 = 1'b0, en1 = 1'b0;
    logic        r0 = 1'b0, r1 = 1'b0;
    logic        kick0 = 1'b0, kick1 = 1'b0;
    logic [31:0] rd0 = 32'h0, rd1 = 32'h0;

    assign s0_ack_i = r0 | kick0;
    assign s1_ack_i = r1 | kick1;

    wb_sub_arbiter dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .s0_cyc_o (s0_cyc_o),
        .s0_stb_o (s0_stb_o),
        .s0_we_o  (s0_we_o),
        .s0_sel_o (s0_sel_o),
        .s0_adr_o (s0_adr_o),
        .s0_dat_o (s0_dat_o),
        .s0_ack_i (s0_ack_i),
        .s0_dat_i (rd0),
        .s1_cyc_o (s1_cyc_o),
        .s1_stb_o (s1_stb_o),
        .s1_we_o  (s1_we_o),
        .s1_sel_o (s1_sel_o),
        .s1_adr_o (s1_adr_o),
        .s1_dat_o (s1_dat_o),
        .s1_ack_i (s1_ack_i),
        .s1_dat_i (rd1),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    // Registered subordinate responders: one-cycle ack pulse after strobe.
    always @(posedge clk) begin
        if (r0) r0 <= 1'b0;
        else if (en0 && s0_cyc_o && s0_stb_o) r0 <= 1'b1;
        if (r1) r1 <= 1'b0;
        else if (en1 && s1_cyc_o && s1_stb_o) r1 <= 1'b1;
    end

    // Monotone activity monitors, sampled just after each rising edge.
    int ack_tot = 0, s0_act = 0, s1_act = 0;
    always @(posedge clk) begin
        #1;
        if (wbs_ack_o) ack_tot = ack_tot + 1;
        if (s0_cyc_o | s0_stb_o | s0_we_o | (|s0_sel_o) | (|s0_adr_o) | (|s0_dat_o))
            s0_act = s0_act + 1;
        if (s1_cyc_o | s1_stb_o | s1_we_o | (|s1_sel_o) | (|s1_adr_o) | (|s1_dat_o))
            s1_act = s1_act + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Outputs seen in cycle 1 (first strobe cycle) of the last transfer.
    logic        sn0_stb, sn1_stb, sn1_we;
    logic [3:0]  sn1_sel;
    logic [31:0] sn0_adr, sn1_adr, sn1_dat;

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input int budget, output logic got, output int lat,
                        output logic [31:0] rdat, output logic irq_ack);
        @(negedge clk);
        adr = a; wdat = d; we = w; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        got = 1'b0; lat = 0; rdat = 32'h0; irq_ack = 1'b0;
        for (int k = 1; k <= budget && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                sn0_stb = s0_stb_o; sn0_adr = s0_adr_o;
                sn1_stb = s1_stb_o; sn1_adr = s1_adr_o; sn1_dat = s1_dat_o;
                sn1_we = s1_we_o; sn1_sel = s1_sel_o;
            end
            if (wbs_ack_o) begin
                got = 1'b1; lat = k; rdat = wbs_dat_o; irq_ack = irq_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    logic        got, ia;
    int          lat, a0, b0, c0;
    logic [31:0] rdat;

    initial begin
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        chk("rst_s0cyc", {31'h0, s0_cyc_o}, 32'h0);
        chk("rst_s1cyc", {31'h0, s1_cyc_o}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read s0: ack in cycle 3 with s0 data, s1 untouched
        en0 = 1'b1; rd0 = 32'h0000_0055;
        a0 = ack_tot; b0 = s1_act;
        xfer(32'h3000_0004, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        @(negedge clk);
        chk("rd0_got", {31'h0, got}, 32'h1);
        chk("rd0_lat", lat, 3);
        chk("rd0_dat", rdat, 32'h55);
        chk("rd0_stb", {31'h0, sn0_stb}, 32'h1);
        chk("rd0_adr", sn0_adr, 32'h3000_0004);
        chk("rd0_s1idle", s1_act - b0, 0);
        chk("rd0_nack", ack_tot - a0, 1);

        // Stray s1 acks during an s0 transfer are ignored
        kick1 = 1'b1; rd0 = 32'h0000_0077;
        xfer(32'h3000_0008, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        kick1 = 1'b0;
        chk("xack_lat", lat, 3);
        chk("xack_dat", rdat, 32'h77);
        en0 = 1'b0;

        // Write s1: write bus carried, single ack, captured s1 data returned
        en1 = 1'b1; rd1 = 32'h0BAD_F00D;
        a0 = ack_tot; b0 = s0_act;
        xfer(32'h3000_0100, 32'hA5A5_A5A5, 1'b1, 40, got, lat, rdat, ia);
        repeat (3) @(negedge clk);
        chk("wr1_lat", lat, 3);
        chk("wr1_sdat", sn1_dat, 32'hA5A5_A5A5);
        chk("wr1_swe", {31'h0, sn1_we}, 32'h1);
        chk("wr1_ssel", {28'h0, sn1_sel}, 32'hF);
        chk("wr1_sadr", sn1_adr, 32'h3000_0100);
        chk("wr1_rdat", rdat, 32'h0BAD_F00D);
        chk("wr1_nack", ack_tot - a0, 1);
        chk("wr1_s0idle", s0_act - b0, 0);
        en1 = 1'b0;

        // Timeout: ack at cycle 17 with error word, irq with it; late ack ignored
        a0 = ack_tot;
        xfer(32'h3000_0000, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        chk("tmo_lat", lat, 17);
        chk("tmo_dat", rdat, 32'hDEADBEEF);
        chk("tmo_irq", {31'h0, ia}, 32'h1);
        repeat (3) @(negedge clk);
        kick0 = 1'b1;
        @(negedge clk);
        kick0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("tmo_nack", ack_tot - a0, 1);
        chk("tmo_s0drop", {31'h0, s0_cyc_o}, 32'h0);
        chk("tmo_sticky", {31'h0, irq_o}, 32'h1);

        // Foreign base: nothing happens for 50 cycles
        a0 = ack_tot; b0 = s0_act; c0 = s1_act;
        xfer(32'h2000_0000, 32'h0, 1'b0, 50, got, lat, rdat, ia);
        chk("base_got", {31'h0, got}, 32'h0);
        chk("base_nack", ack_tot - a0, 0);
        chk("base_s0", s0_act - b0, 0);
        chk("base_s1", s1_act - c0, 0);

        // Master abort in BUSY: strobes drop, no ack
        a0 = ack_tot;
        @(negedge clk);
        adr = 32'h3000_0008; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        repeat (3) @(negedge clk);
        chk("abt_busy", {31'h0, s0_stb_o}, 32'h1);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("abt_drop", {31'h0, s0_cyc_o}, 32'h0);
        repeat (20) @(negedge clk);
        chk("abt_nack", ack_tot - a0, 0);

        // Reset mid-transaction clears everything immediately
        a0 = ack_tot;
        @(negedge clk);
        adr = 32'h3000_0000; cyc = 1'b1; stb = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_pre_stb", {31'h0, s0_stb_o}, 32'h1);
        chk("mrst_pre_dat", wbs_dat_o, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        chk("mrst_stb", {31'h0, s0_stb_o}, 32'h0);
        chk("mrst_adr", s0_adr_o, 32'h0);
        chk("mrst_dat", wbs_dat_o, 32'h0);
        chk("mrst_irq", {31'h0, irq_o}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_nack", ack_tot - a0, 0);

`ifdef WB_ARB_STATS_EN
        // Statistics: 2 s0 acks, 1 s1 ack, 1 timeout -> 0x01001002
        en0 = 1'b1; en1 = 1'b1; rd0 = 32'h1; rd1 = 32'h2;
        xfer(32'h3000_0004, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        xfer(32'h3000_0004, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        xfer(32'h3000_0100, 32'h9, 1'b1, 40, got, lat, rdat, ia);
        en0 = 1'b0; en1 = 1'b0;
        xfer(32'h3000_0000, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        chk("st_tmo_lat", lat, 17);
        b0 = s0_act; c0 = s1_act;
        xfer(32'h3000_00FC, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        chk("st_rd_lat", lat, 2);
        chk("st_rd_dat", rdat, 32'h0100_1002);
        chk("st_rd_local", (s0_act - b0) + (s1_act - c0), 0);
        xfer(32'h3000_00FC, 32'h1234, 1'b1, 40, got, lat, rdat, ia);
        chk("st_wr_lat", lat, 2);
        xfer(32'h3000_00FC, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        chk("st_clr_dat", rdat, 32'h0);
        chk("st_clr_irq", {31'h0, irq_o}, 32'h0);
`else
        // Without statistics, 0xFC is an ordinary s0 address
        en0 = 1'b1; rd0 = 32'h0000_1234;
        xfer(32'h3000_00FC, 32'h0, 1'b0, 40, got, lat, rdat, ia);
        chk("fc_lat", lat, 3);
        chk("fc_dat", rdat, 32'h1234);
        chk("fc_adr", sn0_adr, 32'h3000_00FC);
        en0 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
